// File: rtl/mem_access_unit.sv
// Data-memory initiator: sequences load/store requests onto a byte/dword-write memory port.
// Optional MEM_ACCESS_RANGE_CHECK_EN flags requests outside [DATA_START, DATA_START+DATA_BYTES).
module mem_access_unit #(
   parameter logic [63:0] DATA_START = 64'h10000000,
   parameter logic [63:0] DATA_BYTES = 64'h8000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_error,
   output logic [63:0] resp_rdata,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic        mem_word_we,
   output logic        mem_byte_we,
   input  logic [63:0] mem_rdata
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LOAD = 3'd1;
   localparam logic [2:0] STB  = 3'd2;
   localparam logic [2:0] STD  = 3'd3;
   localparam logic [2:0] RESP = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [1:0]  cnt_q, cnt_d;

   logic        req_ready_d, resp_valid_d, resp_error_d;
   logic [63:0] resp_rdata_d, mem_addr_d, mem_wdata_d;
   logic        mem_word_we_d, mem_byte_we_d;

   logic        misaligned, range_err, req_err;
   logic [1:0]  last_cnt;
   logic [63:0] lane, load_ext;

   always_comb begin
      misaligned = 1'b0;
      case (req_size)
         2'd1:    misaligned = req_addr[0];
         2'd2:    misaligned = |req_addr[1:0];
         2'd3:    misaligned = |req_addr[2:0];
         default: misaligned = 1'b0;
      endcase
   end

`ifdef MEM_ACCESS_RANGE_CHECK_EN
   // 65-bit sums so a request ending exactly at 2^64 is not mistaken for a small address
   logic [64:0] req_end, seg_end;
   always_comb begin
      req_end   = {1'b0, req_addr} + (65'd1 << req_size);
      seg_end   = {1'b0, DATA_START} + {1'b0, DATA_BYTES};
      range_err = (req_addr < DATA_START) || (req_end > seg_end);
   end
`else
   logic unused_range_params;
   assign unused_range_params = ^{DATA_START, DATA_BYTES};
   assign range_err = 1'b0;
`endif

   assign req_err = (req_load && req_store) || misaligned || range_err;

   always_comb begin
      case (size_q)
         2'd0:    last_cnt = 2'd0;
         2'd1:    last_cnt = 2'd1;
         default: last_cnt = 2'd3;
      endcase
   end

   assign lane = mem_rdata >> {addr_q[2:0], 3'b000};

   always_comb begin
      case (size_q)
         2'd0:    load_ext = signed_q ? {{56{lane[7]}}, lane[7:0]}   : {56'b0, lane[7:0]};
         2'd1:    load_ext = signed_q ? {{48{lane[15]}}, lane[15:0]} : {48'b0, lane[15:0]};
         2'd2:    load_ext = signed_q ? {{32{lane[31]}}, lane[31:0]} : {32'b0, lane[31:0]};
         default: load_ext = lane;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      size_d        = size_q;
      signed_d      = signed_q;
      cnt_d         = cnt_q;
      req_ready_d   = 1'b0;
      resp_valid_d  = 1'b0;
      resp_error_d  = 1'b0;
      resp_rdata_d  = 64'b0;
      mem_addr_d    = mem_addr;
      mem_wdata_d   = mem_wdata;
      mem_word_we_d = 1'b0;
      mem_byte_we_d = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready && (req_load || req_store)) begin
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               size_d      = req_size;
               signed_d    = req_signed;
               cnt_d       = 2'd0;
               req_ready_d = 1'b0;
               if (req_err) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
               end else if (req_load) begin
                  state_d    = LOAD;
                  mem_addr_d = {req_addr[63:3], 3'b000};
               end else if (req_size == 2'd3) begin
                  state_d       = STD;
                  mem_addr_d    = req_addr;
                  mem_wdata_d   = req_wdata;
                  mem_word_we_d = 1'b1;
               end else begin
                  state_d       = STB;
                  mem_addr_d    = req_addr;
                  mem_wdata_d   = {56'b0, req_wdata[7:0]};
                  mem_byte_we_d = 1'b1;
               end
            end
         end
         LOAD: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_ext;
         end
         STD: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         STB: begin
            if (cnt_q == last_cnt) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
            end else begin
               cnt_d         = cnt_q + 2'd1;
               mem_addr_d    = addr_q + {62'b0, cnt_d};
               mem_wdata_d   = {56'b0, wdata_q[{cnt_d, 3'b000} +: 8]};
               mem_byte_we_d = 1'b1;
            end
         end
         RESP: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= 64'b0;
         wdata_q     <= 64'b0;
         size_q      <= 2'd0;
         signed_q    <= 1'b0;
         cnt_q       <= 2'd0;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_error  <= 1'b0;
         resp_rdata  <= 64'b0;
         mem_addr    <= 64'b0;
         mem_wdata   <= 64'b0;
         mem_word_we <= 1'b0;
         mem_byte_we <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         cnt_q       <= cnt_d;
         req_ready   <= req_ready_d;
         resp_valid  <= resp_valid_d;
         resp_error  <= resp_error_d;
         resp_rdata  <= resp_rdata_d;
         mem_addr    <= mem_addr_d;
         mem_wdata   <= mem_wdata_d;
         mem_word_we <= mem_word_we_d;
         mem_byte_we <= mem_byte_we_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small data-memory model covering 0x10000000..0x1000007F.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_load, req_store, req_signed;
   logic [1:0]  req_size;
   logic [63:0] req_addr, req_wdata;
   logic        resp_valid, resp_error;
   logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_word_we, mem_byte_we;

   int n_cmp = 0;
   int n_bad = 0;

   mem_access_unit dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_load   (req_load),
      .req_store  (req_store),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_error (resp_error),
      .resp_rdata (resp_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_word_we(mem_word_we),
      .mem_byte_we(mem_byte_we),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: 16 dwords, writes commit on negedge, reads are combinational
   logic [63:0] mem [0:15] = '{default: 64'h0};
   logic        in_rng;
   logic [63:0] wr_addr [0:63];
   logic [63:0] wr_data [0:63];
   int          byte_cnt = 0;
   int          word_cnt = 0;

   assign in_rng    = (mem_addr[63:7] == 57'h200000);
   assign mem_rdata = in_rng ? mem[mem_addr[6:3]] : 64'h0;

   always @(negedge clk) begin
      if (mem_byte_we) begin
         wr_addr[byte_cnt[5:0]] <= mem_addr;
         wr_data[byte_cnt[5:0]] <= mem_wdata;
         byte_cnt <= byte_cnt + 1;
         if (in_rng) mem[mem_addr[6:3]][{mem_addr[2:0], 3'b000} +: 8] <= mem_wdata[7:0];
      end
      if (mem_word_we) begin
         word_cnt <= word_cnt + 1;
         if (in_rng) mem[mem_addr[6:3]] <= mem_wdata;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int tries = 0;
      @(negedge clk);
      while (!req_ready && tries < 20) begin
         @(negedge clk);
         tries++;
      end
   endtask

   // Issues one request and returns latency in edges (accept edge counts as 1)
   task automatic run_req(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                          input logic [63:0] a, input logic [63:0] wd,
                          output int lat, output logic err, output logic [63:0] rd);
      wait_ready();
      req_valid = 1'b1; req_load = ld; req_store = st; req_size = sz;
      req_signed = sg; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      // scramble inputs so in-flight operation must use captured values
      req_valid = 1'b0; req_load = ~ld; req_store = ~st; req_size = ~sz;
      req_signed = ~sg; req_addr = ~a; req_wdata = ~wd;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      err = resp_error;
      rd  = resp_rdata;
   endtask

   int          lat, b0, w0;
   logic        err, seen;
   logic [63:0] rd;

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
      req_size = 2'd0; req_signed = 1'b0; req_addr = 64'h0; req_wdata = 64'h0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ready", {63'b0, req_ready}, 64'd1);
      check_eq("rst_rvalid", {63'b0, resp_valid}, 64'd0);
      check_eq("rst_rerror", {63'b0, resp_error}, 64'd0);
      check_eq("rst_rdata", resp_rdata, 64'd0);
      check_eq("rst_maddr", mem_addr, 64'd0);
      check_eq("rst_mwdata", mem_wdata, 64'd0);
      check_eq("rst_wwe", {63'b0, mem_word_we}, 64'd0);
      check_eq("rst_bwe", {63'b0, mem_byte_we}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Byte store then signed/unsigned loads
      b0 = byte_cnt;
      run_req(1'b0, 1'b1, 2'd0, 1'b0, 64'h10000005, 64'hABCD_EF01_2345_6780, lat, err, rd);
      check_eq("sb_lat", 64'(lat), 64'd2);
      check_eq("sb_err", {63'b0, err}, 64'd0);
      check_eq("sb_rdata", rd, 64'd0);
      check_eq("sb_nwr", 64'(byte_cnt - b0), 64'd1);
      check_eq("sb_addr", wr_addr[b0[5:0]], 64'h10000005);
      check_eq("sb_data", wr_data[b0[5:0]], 64'h80);
      run_req(1'b1, 1'b0, 2'd0, 1'b1, 64'h10000005, 64'h0, lat, err, rd);
      check_eq("lb_lat", 64'(lat), 64'd2);
      check_eq("lb_data", rd, 64'hFFFF_FFFF_FFFF_FF80);
      run_req(1'b1, 1'b0, 2'd0, 1'b0, 64'h10000005, 64'h0, lat, err, rd);
      check_eq("lbu_data", rd, 64'h80);
      run_req(1'b1, 1'b0, 2'd1, 1'b1, 64'h10000004, 64'h0, lat, err, rd);
      check_eq("lh_data", rd, 64'hFFFF_FFFF_FFFF_8000);

      // Word store: four byte writes, little-endian order
      b0 = byte_cnt;
      run_req(1'b0, 1'b1, 2'd2, 1'b0, 64'h10000004, 64'hDEAD_BEEF_1122_3344, lat, err, rd);
      check_eq("sw_lat", 64'(lat), 64'd5);
      check_eq("sw_nwr", 64'(byte_cnt - b0), 64'd4);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("sw_addr%0d", i), wr_addr[(b0 + i) % 64], 64'h10000004 + 64'(i));
         check_eq($sformatf("sw_data%0d", i), wr_data[(b0 + i) % 64],
                  64'((32'h11223344 >> (8 * i)) & 32'hFF));
      end
      run_req(1'b1, 1'b0, 2'd3, 1'b0, 64'h10000000, 64'h0, lat, err, rd);
      check_eq("ld_after_sw", rd, 64'h1122_3344_0000_0000);
      run_req(1'b1, 1'b0, 2'd2, 1'b1, 64'h10000004, 64'h0, lat, err, rd);
      check_eq("lw_signed_pos", rd, 64'h0000_0000_1122_3344);

      // Dword store / load
      w0 = word_cnt; b0 = byte_cnt;
      run_req(1'b0, 1'b1, 2'd3, 1'b0, 64'h10000010, 64'h0123_4567_89AB_CDEF, lat, err, rd);
      check_eq("sd_lat", 64'(lat), 64'd2);
      check_eq("sd_nword", 64'(word_cnt - w0), 64'd1);
      check_eq("sd_nbyte", 64'(byte_cnt - b0), 64'd0);
      run_req(1'b1, 1'b0, 2'd3, 1'b0, 64'h10000010, 64'h0, lat, err, rd);
      check_eq("ld_lat", 64'(lat), 64'd2);
      check_eq("ld_data", rd, 64'h0123_4567_89AB_CDEF);

      // Error cases: misaligned half store, load+store
      w0 = word_cnt; b0 = byte_cnt;
      run_req(1'b0, 1'b1, 2'd1, 1'b0, 64'h10000001, 64'hFFFF, lat, err, rd);
      check_eq("mis_lat", 64'(lat), 64'd1);
      check_eq("mis_err", {63'b0, err}, 64'd1);
      check_eq("mis_rdata", rd, 64'd0);
      run_req(1'b1, 1'b1, 2'd0, 1'b0, 64'h10000008, 64'h55, lat, err, rd);
      check_eq("ldst_lat", 64'(lat), 64'd1);
      check_eq("ldst_err", {63'b0, err}, 64'd1);
      repeat (2) @(posedge clk);
      check_eq("err_no_we", 64'((word_cnt - w0) + (byte_cnt - b0)), 64'd0);

      // Neither load nor store: ignored
      wait_ready();
      req_valid = 1'b1; req_load = 1'b0; req_store = 1'b0; req_addr = 64'h10000008;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (resp_valid || !req_ready) seen = 1'b1;
      end
      req_valid = 1'b0;
      check_eq("nop_ignored", {63'b0, seen}, 64'd0);

      // Reset during the 2nd byte cycle of a word store
      run_req(1'b0, 1'b1, 2'd3, 1'b0, 64'h10000020, 64'hFFFF_FFFF_FFFF_FFFF, lat, err, rd);
      wait_ready();
      b0 = byte_cnt;
      req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_size = 2'd2;
      req_signed = 1'b0; req_addr = 64'h10000020; req_wdata = 64'h5566_7788;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check_eq("mr_bwe", {63'b0, mem_byte_we}, 64'd0);
      check_eq("mr_ready", {63'b0, req_ready}, 64'd1);
      check_eq("mr_rvalid", {63'b0, resp_valid}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (resp_valid) seen = 1'b1;
      end
      check_eq("mr_no_resp", {63'b0, seen}, 64'd0);
      check_eq("mr_nwr", 64'(byte_cnt - b0), 64'd2);
      run_req(1'b1, 1'b0, 2'd3, 1'b0, 64'h10000020, 64'h0, lat, err, rd);
      check_eq("mr_mem", rd, 64'hFFFF_FFFF_FFFF_7788);

      // Below the data segment
      run_req(1'b1, 1'b0, 2'd3, 1'b0, 64'h0FFFFFF8, 64'h0, lat, err, rd);
`ifdef MEM_ACCESS_RANGE_CHECK_EN
      check_eq("rng_lat", 64'(lat), 64'd1);
      check_eq("rng_err", {63'b0, err}, 64'd1);
`else
      check_eq("rng_lat", 64'(lat), 64'd2);
      check_eq("rng_err", {63'b0, err}, 64'd0);
      check_eq("rng_rdata", rd, 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the data-memory port. It accepts one load/store request at a time from the pipeline MEM stage and drives the data memory's addr/data_in/word_we/byte_we and data_out interface. Byte, half, word and doubleword stores are sequenced into single-byte or full-doubleword memory writes. Loads are returned byte-lane extracted and zero- or sign-extended. Addressing is little-endian: byte k of a doubleword is bits [8k+7:8k].

Parameters:
DATA_START, 64'h10000000, base byte address of the data segment.
DATA_BYTES, 64'h8000, size of the data segment in bytes; used only with the optional feature.

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request; high only in IDLE
req_load  in  1  request is a load
req_store  in  1  request is a store
req_size  in  2  0=byte, 1=half, 2=word, 3=dword
req_signed  in  1  load result is sign-extended (ignored for dword and stores)
req_addr  in  64  byte address
req_wdata  in  64  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_error  out  1  qualifies resp_valid: misaligned or illegal request
resp_rdata  out  64  load result; 0 for stores and errors
mem_addr  out  64  to memory addr
mem_wdata  out  64  to memory data_in
mem_word_we  out  1  doubleword write enable
mem_byte_we  out  1  byte write enable (memory writes data_in[7:0] at mem_addr)
mem_rdata  in  64  memory data_out; combinational from mem_addr

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE, req_ready=1.
  - resp_valid=0, resp_error=0, resp_rdata=0.
  - mem_addr=0, mem_wdata=0, mem_word_we=0, mem_byte_we=0.
- Accept: a request is accepted at a posedge where req_valid && req_ready.
- Accepted request with neither req_load nor req_store: ignored, no response, stays IDLE.
- Error check at accept:
  - Error if req_load && req_store.
  - Error if misaligned: addr[0]!=0 for half, addr[1:0]!=0 for word, addr[2:0]!=0 for dword.
  - On error: state -> RESP with resp_error=1. No memory enable is ever asserted.
- States: IDLE, LOAD, STB (byte-store sequencing), STD (dword store), RESP.
- LOAD (1 cycle):
  - mem_addr = {req_addr[63:3],3'b0}.
  - At the closing edge, capture the lane (shift right by 8*addr[2:0]), then zero- or sign-extend to 64 bits per req_signed and size. Dword is passed unchanged.
  - -> RESP.
- STD (1 cycle): mem_addr=req_addr, mem_wdata=req_wdata, mem_word_we=1 -> RESP.
- STB: counter n runs 0..N-1, with N = 1/2/4 for byte/half/word.
  - Each cycle: mem_addr=req_addr+n, mem_wdata={56'b0, req_wdata[8n+7:8n]}, mem_byte_we=1.
  - After n=N-1 -> RESP.
- Memory commits writes on the negedge inside each enabled cycle, so exactly one write happens per enabled cycle.
- RESP (1 cycle): resp_valid=1, all we=0, req_ready=0 -> IDLE.
- Latency, accept edge to resp_valid high:
  - load: 2 cycles.
  - dword store: 2 cycles.
  - byte/half/word store: N+1 cycles.
  - error: 1 cycle.
- Request inputs are captured at accept. Later changes to the req_* inputs have no effect on the operation in flight.
- Enables are low in IDLE and RESP, so no back-to-back write overlap is possible.
- Reset mid-operation: the next edge forces the reset values. Bytes already written stay written, and no response is issued.
- Address arithmetic is 64-bit and wraps modulo 2^64. It only matters for byte stores near the top of the address space.

Optional Feature:
- Macro: MEM_ACCESS_RANGE_CHECK_EN.
- Defined:
  - An aligned request with req_addr < DATA_START or req_addr + size_bytes > DATA_START + DATA_BYTES is an error.
  - Response is 1 cycle after accept with resp_error=1 and no memory enables.
- Undefined: no range check. Out-of-range accesses proceed and the memory silently ignores them.

Test Plan:
- Byte store then signed load: store addr 0x10000005, wdata 0x..80, size 0 -> exactly one byte_we cycle with mem_addr 0x10000005, data 0x80. Signed byte load of the same address -> resp_rdata 0xFFFFFFFFFFFFFF80. Unsigned load -> 0x80.
- Word store: addr 0x10000004, wdata 0x11223344 -> 4 byte_we cycles at addresses ..04..07 with data 0x44, 0x33, 0x22, 0x11. resp_valid 5 cycles after accept. Dword load at 0x10000000 -> upper 32 bits 0x11223344.
- Dword store/load: 0x0123456789ABCDEF at 0x10000010 -> a single word_we cycle; the load returns the same value 2 cycles after accept.
- Misaligned half store at 0x10000001 -> resp_valid + resp_error the cycle after accept, resp_rdata=0, no write enables ever high.
- Reset asserted during the 2nd byte cycle of a word store -> next cycle all enables 0, req_ready=1, no resp_valid. Bytes 0 and 1 are updated, bytes 2 and 3 are unchanged.
- With MEM_ACCESS_RANGE_CHECK_EN: dword load at 0x0FFFFFF8 -> resp_error=1. Without the macro -> normal 2-cycle response, resp_error=0.
